// File: rtl/oled_pkg.sv
// Shared types and SSD1306 opcodes for the OLED refresh scheduler.
package oled_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StPgSet,
    StColLo,
    StColHi,
    StFetch,
    StData
  } state_e;

  localparam logic [7:0] PAGE_BASE   = 8'hB0;
  localparam logic [7:0] COL_LO_BASE = 8'h00;
  localparam logic [7:0] COL_HI_BASE = 8'h10;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/oled_addr_gen.sv
// Page/column counters for the refresh walk and the derived framebuffer read address.
module oled_addr_gen #(
  parameter int unsigned COLS  = 128,
  parameter int unsigned PAGES = 8,
  localparam int unsigned AW   = $clog2(COLS * PAGES),
  localparam int unsigned PW   = $clog2(PAGES),
  localparam int unsigned CW   = $clog2(COLS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          col_inc_i,
  input  logic          page_load_i,
  input  logic [PW-1:0] page_val_i,
  output logic [PW-1:0] page_o,
  output logic          last_col_o,
  output logic          last_page_o,
  output logic [AW-1:0] fb_addr_o
);

  logic [PW-1:0] page_q;
  logic [CW-1:0] col_q;

  // Loading a page always restarts its column walk.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      page_q <= '0;
      col_q  <= '0;
    end else if (page_load_i) begin
      page_q <= page_val_i;
      col_q  <= '0;
    end else if (col_inc_i) begin
      col_q <= col_q + 1'b1;
    end
  end

  assign page_o      = page_q;
  assign last_col_o  = (col_q == CW'(COLS - 1));
  assign last_page_o = (page_q == PW'(PAGES - 1));
  assign fb_addr_o   = AW'(page_q) * AW'(COLS) + AW'(col_q);

endmodule

// File: rtl/oled_refresh_scheduler.sv
// Shares the SSD1306 SPI byte shifter between host commands and page-by-page frame refreshes.
// Optional OLED_REFRESH_DIRTY_EN adds a per-page dirty mask sampled when a frame launches.
module oled_refresh_scheduler
  import oled_pkg::*;
#(
  parameter int unsigned COLS  = 128,
  parameter int unsigned PAGES = 8,
  localparam int unsigned AW   = $clog2(COLS * PAGES),
  localparam int unsigned PW   = $clog2(PAGES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_done_i,
  input  logic             cmd_req_i,
  input  logic [7:0]       cmd_byte_i,
  output logic             cmd_ack_o,
  input  logic             frame_start_i,
`ifdef OLED_REFRESH_DIRTY_EN
  input  logic [PAGES-1:0] dirty_i,
`endif
  output logic [AW-1:0]    fb_addr_o,
  input  logic [7:0]       fb_data_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_byte_o,
  output logic             tx_dc_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             frame_done_o
);

  state_e           state_q;
  logic             tx_valid_q, tx_dc_q, cmd_ack_q, frame_done_q;
  logic [7:0]       tx_byte_q;
  logic             pending_q, resume_q, data_fresh_q;
  logic [PAGES-1:0] mask_q, launch_mask;

  logic          accept, cmd_ok, launch;
  logic          pg_load, col_inc, clr;
  logic [PW-1:0] pg_val, page;
  logic          last_col, last_page;
  logic [PW:0]   first_sel, next_sel;

`ifdef OLED_REFRESH_DIRTY_EN
  assign launch_mask = dirty_i;
`else
  assign launch_mask = '1;
`endif

  // Returns {found, index} of the lowest set mask bit at or above from.
  function automatic logic [PW:0] find_page(input logic [PAGES-1:0] m, input int unsigned from);
    logic [PW:0] r;
    r = '0;
    for (int i = int'(PAGES) - 1; i >= 0; i--) begin
      if (i >= int'(from) && m[i]) r = {1'b1, PW'(i)};
    end
    return r;
  endfunction

  assign first_sel = find_page(launch_mask, 0);
  assign next_sel  = last_page ? '0 : find_page(mask_q, 32'(page) + 32'd1);

  assign accept = tx_valid_q && tx_ready_i;
  // Ignore a request still high in the cycle its ack is visible.
  assign cmd_ok = cmd_req_i && !cmd_ack_q;
  assign launch = (state_q == StIdle) && init_done_i && !cmd_ok && pending_q;

  always_comb begin
    pg_load = 1'b0;
    pg_val  = first_sel[PW-1:0];
    col_inc = 1'b0;
    clr     = 1'b0;
    if (launch && first_sel[PW]) pg_load = 1'b1;
    if (state_q == StData && accept) begin
      if (!last_col) begin
        col_inc = 1'b1;
      end else if (next_sel[PW]) begin
        pg_load = 1'b1;
        pg_val  = next_sel[PW-1:0];
      end else begin
        clr = 1'b1;
      end
    end
  end

  oled_addr_gen #(
    .COLS  (COLS),
    .PAGES (PAGES)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clr),
    .col_inc_i   (col_inc),
    .page_load_i (pg_load),
    .page_val_i  (pg_val),
    .page_o      (page),
    .last_col_o  (last_col),
    .last_page_o (last_page),
    .fb_addr_o   (fb_addr_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
      tx_dc_q      <= DC_CMD;
      cmd_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      resume_q     <= 1'b0;
      data_fresh_q <= 1'b0;
      mask_q       <= '0;
    end else begin
      cmd_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      data_fresh_q <= 1'b0;
      // Pending is consumed at launch so requests during a frame queue exactly one more.
      if (frame_start_i) pending_q <= 1'b1;
      else if (launch)   pending_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (init_done_i) begin
            if (cmd_ok) begin
              state_q    <= StCmd;
              tx_valid_q <= 1'b1;
              tx_byte_q  <= cmd_byte_i;
              tx_dc_q    <= DC_CMD;
            end else if (pending_q) begin
              mask_q <= launch_mask;
              if (first_sel[PW]) begin
                state_q    <= StPgSet;
                tx_valid_q <= 1'b1;
                tx_byte_q  <= PAGE_BASE | 8'(first_sel[PW-1:0]);
                tx_dc_q    <= DC_CMD;
              end else begin
                frame_done_q <= 1'b1;
              end
            end
          end
        end
        StCmd: begin
          if (accept) begin
            cmd_ack_q <= 1'b1;
            if (resume_q) begin
              resume_q  <= 1'b0;
              state_q   <= StPgSet;
              tx_byte_q <= PAGE_BASE | 8'(page);
            end else begin
              state_q    <= StIdle;
              tx_valid_q <= 1'b0;
            end
          end
        end
        StPgSet: begin
          if (accept) begin
            state_q   <= StColLo;
            tx_byte_q <= COL_LO_BASE;
          end
        end
        StColLo: begin
          if (accept) begin
            state_q   <= StColHi;
            tx_byte_q <= COL_HI_BASE;
          end
        end
        StColHi: begin
          if (accept) begin
            state_q    <= StFetch;
            tx_valid_q <= 1'b0;
          end
        end
        StFetch: begin
          state_q      <= StData;
          tx_valid_q   <= 1'b1;
          tx_dc_q      <= DC_DATA;
          data_fresh_q <= 1'b1;
        end
        StData: begin
          if (data_fresh_q) tx_byte_q <= fb_data_i;
          if (accept) begin
            if (!last_col) begin
              state_q    <= StFetch;
              tx_valid_q <= 1'b0;
            end else if (next_sel[PW]) begin
              tx_dc_q <= DC_CMD;
              if (cmd_ok) begin
                state_q   <= StCmd;
                tx_byte_q <= cmd_byte_i;
                resume_q  <= 1'b1;
              end else begin
                state_q   <= StPgSet;
                tx_byte_q <= PAGE_BASE | 8'(next_sel[PW-1:0]);
              end
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= StIdle;
              tx_valid_q   <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data arrives in the first DATA cycle; it is registered there and held through stalls.
  assign tx_byte_o    = (state_q == StData && data_fresh_q) ? fb_data_i : tx_byte_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_dc_o      = tx_dc_q;
  assign cmd_ack_o    = cmd_ack_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Randomized self-checking bench for oled_refresh_scheduler against a byte-stream model.
module tb_oled_refresh_scheduler;

  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int AW    = 10;
  localparam int PAGE_WORDS = 3 + COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          cmd_req = 1'b0;
  logic [7:0]    cmd_byte = 8'h00;
  logic          frame_start = 1'b0;
  logic          tx_ready = 1'b1;
  logic [7:0]    fb_data;
  logic [AW-1:0] fb_addr;
  logic          cmd_ack, tx_valid, tx_dc, busy, frame_done;
  logic [7:0]    tx_byte;
`ifdef OLED_REFRESH_DIRTY_EN
  logic [PAGES-1:0] dirty = '1;
`endif

  oled_refresh_scheduler dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .init_done_i   (init_done),
    .cmd_req_i     (cmd_req),
    .cmd_byte_i    (cmd_byte),
    .cmd_ack_o     (cmd_ack),
    .frame_start_i (frame_start),
`ifdef OLED_REFRESH_DIRTY_EN
    .dirty_i       (dirty),
`endif
    .fb_addr_o     (fb_addr),
    .fb_data_i     (fb_data),
    .tx_valid_o    (tx_valid),
    .tx_byte_o     (tx_byte),
    .tx_dc_o       (tx_dc),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy),
    .frame_done_o  (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [COLS*PAGES];
  always @(posedge clk) fb_data <= mem[fb_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit ready_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  int valid_cycles, ack_count, done_count, first_valid_cyc, done_cyc, stall_cnt, stall_viol;
  bit prev_stall = 1'b0;
  logic [8:0] prev_word;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cnt++;
        if (!tx_valid || {tx_dc, tx_byte} !== prev_word) stall_viol++;
      end
      if (tx_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (tx_valid && tx_ready) rx_q.push_back({tx_dc, tx_byte});
      if (cmd_ack) ack_count++;
      if (frame_done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_dc, tx_byte};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    valid_cycles = 0; ack_count = 0; done_count = 0; done_cyc = 0;
    stall_cnt = 0; stall_viol = 0; first_valid_cyc = -1;
  endtask

  // Expected SSD1306 traffic for one frame restricted to the pages in mask.
  task automatic add_frame(input logic [7:0] mask);
    for (int p = 0; p < PAGES; p++) begin
      if (mask[p]) begin
        exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h010);
        for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, mem[p*COLS + c]});
      end
    end
  endtask

  // -1 when identical, else index of first difference (or shorter length).
  function automatic int stream_diff();
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    return (rx_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_count < target; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (tx_valid !== 1'b0 || tx_dc !== 1'b0) $display("FAIL reset_tx: valid=%b dc=%b want 0 0", tx_valid, tx_dc);
    else n_pass++;
    n_checks++;
    if (tx_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", tx_byte);
    else n_pass++;
    n_checks++;
    if (cmd_ack !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_flags: ack=%b done=%b busy=%b want 0 0 0", cmd_ack, frame_done, busy);
    else n_pass++;
    n_checks++;
    if (fb_addr !== '0) $display("FAIL reset_addr: got %0d want 0", fb_addr);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int fs, d;
    init_done = 1'b1;
    clear_mon();
    add_frame(8'hFF);
    fs = cyc;
    pulse_frame();
    wait_done(1, 2300);
    repeat (5) tick();
    n_checks++;
    if (done_count !== 1) $display("FAIL frame_done_count: got %0d want 1", done_count);
    else n_pass++;
    n_checks++;
    if (first_valid_cyc - fs !== 2) $display("FAIL frame_start_latency: got %0d want 2", first_valid_cyc - fs);
    else n_pass++;
    n_checks++;
    if (done_cyc - first_valid_cyc !== 2072)
      $display("FAIL frame_length: got %0d want 2072", done_cyc - first_valid_cyc);
    else n_pass++;
    d = stream_diff();
    n_checks++;
    if (d !== -1) $display("FAIL frame_stream: diff at %0d, size got %0d want %0d", d, rx_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int d;
    clear_mon();
    add_frame(8'hFF);
    ready_rand = 1'b1;
    pulse_frame();
    wait_done(1, 20000);
    ready_rand = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (done_count !== 1) $display("FAIL bp_done: got %0d want 1", done_count);
    else n_pass++;
    d = stream_diff();
    n_checks++;
    if (d !== -1) $display("FAIL bp_stream: diff at %0d, size got %0d want %0d", d, rx_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0 || stall_cnt == 0)
      $display("FAIL bp_stable: violations %0d want 0, stalls seen %0d want >0", stall_viol, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_cmd_mid_frame();
    int d;
    clear_mon();
    add_frame(8'h07);
    exp_q.push_back({1'b0, 8'h81});
    add_frame(8'hF8);
    pulse_frame();
    for (int i = 0; i < 3000 && rx_q.size() < 2*PAGE_WORDS + 3 + 20; i++) tick();
    cmd_byte = 8'h81;
    cmd_req  = 1'b1;
    for (int i = 0; i < 3000 && done_count < 1; i++) begin
      tick();
      if (cmd_ack) cmd_req = 1'b0;
    end
    cmd_req = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (ack_count !== 1) $display("FAIL cmd_ack_count: got %0d want 1", ack_count);
    else n_pass++;
    d = stream_diff();
    n_checks++;
    if (d !== -1) $display("FAIL cmd_stream: diff at %0d, size got %0d want %0d", d, rx_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_merged();
    int d;
    clear_mon();
    add_frame(8'hFF);
    add_frame(8'hFF);
    pulse_frame();
    repeat (300) tick();
    pulse_frame();
    repeat (500) tick();
    pulse_frame();
    repeat (500) tick();
    pulse_frame();
    wait_done(2, 5000);
    repeat (2200) tick();
    n_checks++;
    if (done_count !== 2) $display("FAIL merged_frames: got %0d want 2", done_count);
    else n_pass++;
    d = stream_diff();
    n_checks++;
    if (d !== -1) $display("FAIL merged_stream: diff at %0d, size got %0d want %0d", d, rx_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL merged_idle: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_gating();
    init_done = 1'b0;
    clear_mon();
    pulse_frame();
    cmd_byte = 8'hAE;
    cmd_req  = 1'b1;
    repeat (60) tick();
    n_checks++;
    if (valid_cycles !== 0) $display("FAIL gate_valid: tx_valid cycles got %0d want 0", valid_cycles);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL gate_busy: got %b want 0", busy);
    else n_pass++;
    cmd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    init_done = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int d;
    clear_mon();
    pulse_frame();
    for (int i = 0; i < 3000 && rx_q.size() < 4*PAGE_WORDS + 3 + 50; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || tx_dc !== 1'b0)
      $display("FAIL rstmid_tx: valid=%b byte=%h dc=%b want 0 00 0", tx_valid, tx_byte, tx_dc);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || fb_addr !== '0 || cmd_ack !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL rstmid_state: busy=%b addr=%0d ack=%b done=%b want 0 0 0 0",
               busy, fb_addr, cmd_ack, frame_done);
    else n_pass++;
    rst = 1'b0;
    tick();
    clear_mon();
    add_frame(8'hFF);
    pulse_frame();
    wait_done(1, 2300);
    tick();
    n_checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 9'h0B0)
      $display("FAIL rstmid_restart: first word got %h want 0b0", (rx_q.size() == 0) ? 9'h1FF : rx_q[0]);
    else n_pass++;
    d = stream_diff();
    n_checks++;
    if (d !== -1) $display("FAIL rstmid_stream: diff at %0d, size got %0d want %0d", d, rx_q.size(), exp_q.size());
    else n_pass++;
  endtask

`ifdef OLED_REFRESH_DIRTY_EN
  task automatic test_dirty();
    int d;
    clear_mon();
    dirty = 8'b0000_0101;
    add_frame(8'b0000_0101);
    pulse_frame();
    wait_done(1, 2300);
    tick();
    d = stream_diff();
    n_checks++;
    if (done_count !== 1 || d !== -1)
      $display("FAIL dirty_stream: done %0d want 1, diff at %0d, size got %0d want %0d",
               done_count, d, rx_q.size(), exp_q.size());
    else n_pass++;
    clear_mon();
    dirty = '0;
    pulse_frame();
    wait_done(1, 10);
    tick();
    n_checks++;
    if (done_count !== 1 || valid_cycles !== 0)
      $display("FAIL dirty_empty: done %0d want 1, tx_valid cycles %0d want 0", done_count, valid_cycles);
    else n_pass++;
    dirty = '1;
  endtask
`endif

  initial begin
    for (int i = 0; i < COLS*PAGES; i++) mem[i] = 8'($urandom);
    clear_mon();
    test_reset();
    test_frame();
    test_backpressure();
    test_cmd_mid_frame();
    test_merged();
    test_gating();
    test_reset_mid();
`ifdef OLED_REFRESH_DIRTY_EN
    test_dirty();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
